goodcrc_tx: RTL and testbench

Builds and transmits the GoodCRC control message that acknowledges each valid incoming PD message. Sits directly downstream of `rx`: `rx` requests an acknowledgement for the MessageID and SOP* it just received, and this block does the following:
- assembles the 16-bit header from MESSAGE_HEADER_INFO;
- appends the CRC-32;
- streams the 6-byte frame to the PHY transmitter over a valid/ready byte interface;
- returns GoodCRC_Transmission_Complete to `rx`.

---
 rtl/goodcrc_tx_if.sv | 28 ++
 rtl/goodcrc_tx.sv | 178 +++++++++++++++++
 tb/tb_goodcrc_tx.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/goodcrc_tx_if.sv
// Byte-wide valid/ready stream from the GoodCRC builder to the PHY transmitter.
// The master side drives the frame; the slave side (PHY) returns ready.
interface goodcrc_tx_if;
  logic [7:0] phy_tx_data;
  logic       phy_tx_valid;
  logic       phy_tx_ready;
  logic       phy_tx_first;
  logic       phy_tx_last;
  logic [1:0] phy_tx_sop_type;

  modport master (
    output phy_tx_data,
    output phy_tx_valid,
    output phy_tx_first,
    output phy_tx_last,
    output phy_tx_sop_type,
    input  phy_tx_ready
  );

  modport slave (
    input  phy_tx_data,
    input  phy_tx_valid,
    input  phy_tx_first,
    input  phy_tx_last,
    input  phy_tx_sop_type,
    output phy_tx_ready
  );
endinterface

// File: rtl/goodcrc_tx.sv
// GoodCRC acknowledgement transmitter: latches a 16-bit header on request from rx,
// appends CRC-32 and streams the 6-byte frame to the PHY with a stall timeout.
module goodcrc_tx #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                hard_reset,
  input  logic                goodcrc_req,
  input  logic [2:0]          rx_message_id,
  input  logic [1:0]          rx_sop_type,
  input  logic [7:0]          MESSAGE_HEADER_INFO,
  goodcrc_tx_if.master        phy,
  output logic                GoodCRC_Transmission_Complete,
  output logic                goodcrc_tx_failed,
  output logic                busy
);

  localparam int unsigned STALL_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, CRC0, CRC1, CRC2, CRC3
  } state_t;

  state_t             state;
  logic [15:0]        hdr;
  logic [31:0]        crc;
  logic [STALL_W-1:0] stall_cnt;

  logic [15:0] hdr_next;
  logic [7:0]  crc_in_byte;
  logic [31:0] crc_acc;
  logic [31:0] crc_fin;
  logic [7:0]  crc_byte;
  logic        handshake;
  logic        req_ok;
  logic        unused_info_bits;

  function automatic logic [15:0] build_header(input logic [7:0] info,
                                               input logic [2:0] msg_id,
                                               input logic [1:0] sop);
    logic [15:0] h;
    logic        is_sop;
    is_sop  = (sop == 2'd0);
    h       = '0;
    h[4:0]  = 5'b00001;
    h[5]    = is_sop ? info[3] : 1'b0;
    h[7:6]  = info[2:1];
    h[8]    = is_sop ? info[0] : info[4];
    h[11:9] = msg_id;
    return h;
  endfunction

  // Non-reflected register fed LSB-first per byte; equivalent to the reflected CRC-32.
  function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_finalize(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  assign unused_info_bits = ^MESSAGE_HEADER_INFO[7:5];
  assign hdr_next    = build_header(MESSAGE_HEADER_INFO, rx_message_id, rx_sop_type);
  assign req_ok      = goodcrc_req && (rx_sop_type != 2'd3);
  assign handshake   = phy.phy_tx_valid && phy.phy_tx_ready;
  assign crc_in_byte = (state == HDR0) ? hdr[7:0] : hdr[15:8];
  assign crc_acc     = crc_update(crc, crc_in_byte);
  // In HDR1 the register still lacks the second header byte, so finalize the look-ahead.
  assign crc_fin     = crc_finalize((state == HDR1) ? crc_acc : crc);

  always_comb begin
    crc_byte = crc_fin[7:0];
    case (state)
      CRC0:    crc_byte = crc_fin[15:8];
      CRC1:    crc_byte = crc_fin[23:16];
      CRC2:    crc_byte = crc_fin[31:24];
      default: crc_byte = crc_fin[7:0];
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the pulse outputs get a default 0 first and are overridden below.
  always_ff @(posedge clk or posedge hard_reset) begin
    if (hard_reset) begin
      state                         <= IDLE;
      hdr                           <= '0;
      crc                           <= CRC_INIT;
      stall_cnt                     <= '0;
      phy.phy_tx_data               <= '0;
      phy.phy_tx_valid              <= 1'b0;
      phy.phy_tx_first              <= 1'b0;
      phy.phy_tx_last               <= 1'b0;
      phy.phy_tx_sop_type           <= '0;
      GoodCRC_Transmission_Complete <= 1'b0;
      goodcrc_tx_failed             <= 1'b0;
      busy                          <= 1'b0;
    end else begin
      GoodCRC_Transmission_Complete <= 1'b0;
      goodcrc_tx_failed             <= 1'b0;
      if (state == IDLE) begin
        stall_cnt <= '0;
        if (req_ok) begin
          state               <= HDR0;
          hdr                 <= hdr_next;
          crc                 <= CRC_INIT;
          phy.phy_tx_data     <= hdr_next[7:0];
          phy.phy_tx_valid    <= 1'b1;
          phy.phy_tx_first    <= 1'b1;
          phy.phy_tx_last     <= 1'b0;
          phy.phy_tx_sop_type <= rx_sop_type;
          busy                <= 1'b1;
        end
      end else if (handshake) begin
        stall_cnt <= '0;
        case (state)
          HDR0: begin
            state            <= HDR1;
            crc              <= crc_acc;
            phy.phy_tx_data  <= hdr[15:8];
            phy.phy_tx_first <= 1'b0;
          end
          HDR1: begin
            state           <= CRC0;
            crc             <= crc_acc;
            phy.phy_tx_data <= crc_byte;
          end
          CRC0: begin
            state           <= CRC1;
            phy.phy_tx_data <= crc_byte;
          end
          CRC1: begin
            state           <= CRC2;
            phy.phy_tx_data <= crc_byte;
          end
          CRC2: begin
            state           <= CRC3;
            phy.phy_tx_data <= crc_byte;
            phy.phy_tx_last <= 1'b1;
          end
          default: begin
            state                         <= IDLE;
            phy.phy_tx_valid              <= 1'b0;
            phy.phy_tx_first              <= 1'b0;
            phy.phy_tx_last               <= 1'b0;
            busy                          <= 1'b0;
            GoodCRC_Transmission_Complete <= (state == CRC3);
          end
        endcase
      end else if (stall_cnt == STALL_LAST) begin
        // This edge is the TIMEOUT_CYCLES-th stalled cycle on the current byte.
        state             <= IDLE;
        stall_cnt         <= '0;
        phy.phy_tx_valid  <= 1'b0;
        phy.phy_tx_first  <= 1'b0;
        phy.phy_tx_last   <= 1'b0;
        busy              <= 1'b0;
        goodcrc_tx_failed <= 1'b1;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_goodcrc_tx.sv
// Scoreboard bench for goodcrc_tx: expected beats are queued at each accepted request
// and compared at the PHY stream; pulses, timing, timeout and reset are checked too.
module tb_goodcrc_tx;
  localparam int TO = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic [1:0] sop;
  } beat_t;

  logic       clk = 1'b0;
  logic       hard_reset;
  logic       goodcrc_req;
  logic [2:0] rx_message_id;
  logic [1:0] rx_sop_type;
  logic [7:0] MESSAGE_HEADER_INFO;
  logic       GoodCRC_Transmission_Complete;
  logic       goodcrc_tx_failed;
  logic       busy;

  goodcrc_tx_if phy ();

  goodcrc_tx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                           (clk),
    .hard_reset                    (hard_reset),
    .goodcrc_req                   (goodcrc_req),
    .rx_message_id                 (rx_message_id),
    .rx_sop_type                   (rx_sop_type),
    .MESSAGE_HEADER_INFO           (MESSAGE_HEADER_INFO),
    .phy                           (phy.master),
    .GoodCRC_Transmission_Complete (GoodCRC_Transmission_Complete),
    .goodcrc_tx_failed             (goodcrc_tx_failed),
    .busy                          (busy)
  );

  always #5 clk = ~clk;

  beat_t       sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_complete = 0;
  int          n_failed = 0;
  int          n_hs = 0;
  int          n_stall = 0;
  int          complete_cyc = -1;
  int          failed_cyc = -1;
  int          last_stall_cyc = -1;
  logic [47:0] frame_bits = '0;
  bit          toggle_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_header(input logic [7:0] info, input logic [2:0] id,
                                               input logic [1:0] sop);
    logic is_sop;
    is_sop = (sop == 2'd0);
    return {4'h0, id, is_sop ? info[0] : info[4], info[2:1], is_sop & info[3], 5'b00001};
  endfunction

  // Reflected (shift-right) CRC-32 over the two header bytes, final complement applied.
  function automatic logic [31:0] model_crc(input logic [15:0] h);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      r = r ^ {24'h0, h[8*k +: 8]};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return ~r;
  endfunction

  function automatic logic [31:0] crc_residue(input logic [47:0] f);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[31] ^ f[8*k + i];
        c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
      end
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] info, input logic [2:0] id, input logic [1:0] sop);
    logic [15:0] h;
    logic [47:0] bytes;
    h     = model_header(info, id, sop);
    bytes = {model_crc(h), h};
    for (int k = 0; k < 6; k++)
      sb.push_back('{data: bytes[8*k +: 8], first: (k == 0), last: (k == 5), sop: sop});
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    beat_t e;
    if (!hard_reset) begin
      if (phy.phy_tx_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_byte_valid", {31'h0, phy.phy_tx_valid}, 32'h0);
        end else begin
          e = sb[0];
          check("data", {24'h0, phy.phy_tx_data}, {24'h0, e.data});
          check("first", {31'h0, phy.phy_tx_first}, {31'h0, e.first});
          check("last", {31'h0, phy.phy_tx_last}, {31'h0, e.last});
          check("sop_type", {30'h0, phy.phy_tx_sop_type}, {30'h0, e.sop});
          if (phy.phy_tx_ready) begin
            void'(sb.pop_front());
            n_hs++;
            frame_bits = {phy.phy_tx_data, frame_bits[47:8]};
            if (e.last) check("crc_residue", crc_residue(frame_bits), 32'hC704_DD7B);
          end else begin
            n_stall++;
            last_stall_cyc = cyc;
          end
        end
      end
      if (GoodCRC_Transmission_Complete) begin
        n_complete++;
        complete_cyc = cyc;
      end
      if (goodcrc_tx_failed) begin
        n_failed++;
        failed_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_ready) phy.phy_tx_ready = ~phy.phy_tx_ready;
  endtask

  task automatic send(input logic [7:0] info, input logic [2:0] id, input logic [1:0] sop,
                      input bit expect_accept, output int req_cyc);
    MESSAGE_HEADER_INFO = info;
    rx_message_id       = id;
    rx_sop_type         = sop;
    goodcrc_req         = 1'b1;
    if (expect_accept) push_frame(info, id, sop);
    req_cyc = cyc;
    tick();
    goodcrc_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_bound_busy", {31'h0, busy}, 32'h0);
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_data"}, {24'h0, phy.phy_tx_data}, 32'h0);
    check({pfx, "_valid"}, {31'h0, phy.phy_tx_valid}, 32'h0);
    check({pfx, "_first"}, {31'h0, phy.phy_tx_first}, 32'h0);
    check({pfx, "_last"}, {31'h0, phy.phy_tx_last}, 32'h0);
    check({pfx, "_sop"}, {30'h0, phy.phy_tx_sop_type}, 32'h0);
    check({pfx, "_complete"}, {31'h0, GoodCRC_Transmission_Complete}, 32'h0);
    check({pfx, "_failed"}, {31'h0, goodcrc_tx_failed}, 32'h0);
    check({pfx, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rc, rc2, c0, f0, h0, s0, n;
    hard_reset          = 1'b1;
    goodcrc_req         = 1'b0;
    rx_message_id       = '0;
    rx_sop_type         = '0;
    MESSAGE_HEADER_INFO = '0;
    phy.phy_tx_ready    = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    hard_reset = 1'b0;
    tick();

    // SOP basic frame, ready held high: complete 7 cycles after the request cycle.
    c0 = n_complete;
    send(8'h0B, 3'd5, 2'd0, 1'b1, rc);
    check("t1_byte0_valid", {31'h0, phy.phy_tx_valid}, 32'h1);
    check("t1_busy", {31'h0, busy}, 32'h1);
    wait_idle(50);
    check("t1_complete_cnt", n_complete - c0, 1);
    check("t1_complete_cyc", complete_cyc, rc + 7);

    // SOP' with cable plug bit.
    c0 = n_complete;
    send(8'h14, 3'd2, 2'd1, 1'b1, rc);
    wait_idle(50);
    check("t2_complete_cnt", n_complete - c0, 1);

    // Backpressure: ready toggles every cycle.
    c0 = n_complete; h0 = n_hs; s0 = n_stall;
    toggle_ready = 1'b1;
    send(8'h1F, 3'd7, 2'd2, 1'b1, rc);
    wait_idle(100);
    toggle_ready     = 1'b0;
    phy.phy_tx_ready = 1'b1;
    check("t3_handshakes", n_hs - h0, 6);
    check("t3_stalls_seen", {31'h0, (n_stall - s0) > 0}, 32'h1);
    check("t3_complete_cnt", n_complete - c0, 1);

    // Timeout: ready drops after byte1 is accepted.
    c0 = n_complete; f0 = n_failed; h0 = n_hs; s0 = n_stall;
    send(8'h0B, 3'd1, 2'd0, 1'b1, rc);
    n = 0;
    while (n_hs < h0 + 2 && n < 20) begin
      tick();
      n++;
    end
    phy.phy_tx_ready = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("t4_valid_dropped", {31'h0, phy.phy_tx_valid}, 32'h0);
    repeat (3) tick();
    check("t4_stall_cycles", n_stall - s0, TO);
    check("t4_failed_cnt", n_failed - f0, 1);
    check("t4_failed_cyc", failed_cyc, last_stall_cyc + 1);
    check("t4_complete_cnt", n_complete - c0, 0);
    sb.delete();
    phy.phy_tx_ready = 1'b1;
    tick();

    // Hard reset while byte3 (CRC1) is on the bus.
    c0 = n_complete; f0 = n_failed; h0 = n_hs;
    send(8'h0B, 3'd4, 2'd0, 1'b1, rc);
    n = 0;
    while (n_hs < h0 + 3 && n < 20) begin
      tick();
      n++;
    end
    #2 hard_reset = 1'b1;
    #1;
    check_reset_outputs("hrst");
    sb.delete();
    tick();
    hard_reset = 1'b0;
    repeat (10) tick();
    check("t5_handshakes", n_hs - h0, 3);
    check("t5_complete_cnt", n_complete - c0, 0);
    check("t5_failed_cnt", n_failed - f0, 0);

    // Request with invalid SOP* is ignored.
    send(8'h0B, 3'd3, 2'd3, 1'b0, rc);
    check("t6_sop3_busy", {31'h0, busy}, 32'h0);
    check("t6_sop3_valid", {31'h0, phy.phy_tx_valid}, 32'h0);

    // Request while busy is ignored; input changes mid-frame do not disturb the frame.
    c0 = n_complete; h0 = n_hs;
    send(8'h0A, 3'd6, 2'd0, 1'b1, rc);
    tick();
    MESSAGE_HEADER_INFO = 8'h15;
    rx_message_id       = 3'd1;
    rx_sop_type         = 2'd1;
    goodcrc_req         = 1'b1;
    tick();
    goodcrc_req = 1'b0;
    wait_idle(50);
    repeat (8) tick();
    check("t7_handshakes", n_hs - h0, 6);
    check("t7_complete_cnt", n_complete - c0, 1);

    // Back-to-back: new request in the complete-pulse cycle.
    c0 = n_complete;
    send(8'h0B, 3'd3, 2'd0, 1'b1, rc);
    n = 0;
    while (!GoodCRC_Transmission_Complete && n < 20) begin
      tick();
      n++;
    end
    check("t8_complete_seen", {31'h0, GoodCRC_Transmission_Complete}, 32'h1);
    send(8'h0B, 3'd6, 2'd0, 1'b1, rc2);
    check("t8_b2b_valid", {31'h0, phy.phy_tx_valid}, 32'h1);
    check("t8_b2b_first", {31'h0, phy.phy_tx_first}, 32'h1);
    wait_idle(50);
    check("t8_complete_cnt", n_complete - c0, 2);
    check("t8_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
